// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/busy/done handshake and operand/result bus
// for the digit-serial adder/subtractor.
`default_nettype none

interface serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             sat;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, sat, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, sat, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module      : serial_add_sub
// Description : Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle,
//               with signed overflow, optional saturation and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_add_sub_if.slave   bus
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_sat;
  logic [IDX_W-1:0]   r_idx;

  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic [DIGIT-1:0]   w_a_slice;
  logic [DIGIT-1:0]   w_b_slice;
  logic [DIGIT:0]     w_slice;
  logic [WIDTH-1:0]   w_sum_full;
  logic               w_ovf;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The final edge merges the last slice straight into the flags, so the
  // full sum is formed from the stored slices plus the one in flight.
  always_comb begin
    w_last     = (r_idx == LAST_IDX);
    w_a_slice  = r_a[r_idx*DIGIT +: DIGIT];
    w_b_slice  = r_b[r_idx*DIGIT +: DIGIT];
    w_slice    = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{DIGIT{1'b0}}, r_carry};
    w_sum_full = r_sum;
    w_sum_full[r_idx*DIGIT +: DIGIT] = w_slice[DIGIT-1:0];
    w_ovf      = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_full[WIDTH-1] != r_a[WIDTH-1]);
    w_res      = w_sum_full;
    if (r_sat && w_ovf) begin
      w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_sat    <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_sat   <= bus.sat;
            r_sum   <= '0;
            r_idx   <= '0;
          end
        end
        S_BUSY: begin
          r_sum   <= w_sum_full;
          r_carry <= w_slice[DIGIT];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_result <= w_res;
            r_cout   <= w_slice[DIGIT];
            r_ovf    <= w_ovf;
            r_zero   <= (w_res == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub in three
// configurations (16/4, 8/8, 32/1) sharing one stimulus driver.
`default_nettype none

module tb_serial_add_sub;

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        drv_start;
  logic        drv_sub;
  logic        drv_sat;
  logic [31:0] drv_a;
  logic [31:0] drv_b;

  logic        w_busy;
  logic        w_done;
  logic [31:0] w_result;
  logic        w_cout;
  logic        w_ovf;
  logic        w_zero;

  int          tests;
  int          fails;
  exp_t        sb[$];
  logic [31:0] res;

  serial_add_sub_if #(.WIDTH(16)) if16 ();
  serial_add_sub_if #(.WIDTH(8))  if8 ();
  serial_add_sub_if #(.WIDTH(32)) if32 ();

  assign if16.start = drv_start && (sel == 0);
  assign if16.sub   = drv_sub;
  assign if16.sat   = drv_sat;
  assign if16.a     = drv_a[15:0];
  assign if16.b     = drv_b[15:0];
  assign if8.start  = drv_start && (sel == 1);
  assign if8.sub    = drv_sub;
  assign if8.sat    = drv_sat;
  assign if8.a      = drv_a[7:0];
  assign if8.b      = drv_b[7:0];
  assign if32.start = drv_start && (sel == 2);
  assign if32.sub   = drv_sub;
  assign if32.sat   = drv_sat;
  assign if32.a     = drv_a;
  assign if32.b     = drv_b;

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  serial_add_sub #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_sub #(.WIDTH(32), .DIGIT(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    w_busy = 1'b0; w_done = 1'b0; w_result = '0; w_cout = 1'b0; w_ovf = 1'b0; w_zero = 1'b0;
    case (sel)
      0: begin
        w_busy = if16.busy; w_done = if16.done; w_result = {16'd0, if16.result};
        w_cout = if16.cout; w_ovf = if16.ovf; w_zero = if16.zero;
      end
      1: begin
        w_busy = if8.busy; w_done = if8.done; w_result = {24'd0, if8.result};
        w_cout = if8.cout; w_ovf = if8.ovf; w_zero = if8.zero;
      end
      default: begin
        w_busy = if32.busy; w_done = if32.done; w_result = if32.result;
        w_cout = if32.cout; w_ovf = if32.ovf; w_zero = if32.zero;
      end
    endcase
  end

  function automatic int width_of(int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endfunction

  function automatic int ndig_of(int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 32;
  endfunction

  // Reference built from signed/unsigned integer arithmetic.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic s, logic st);
    exp_t   e;
    longint full, half, ua, ub, sa, sbv, sr, raw;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'({32'd0, a}) & (full - 1);
    ub   = longint'({32'd0, b}) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sbv  = (ub >= half) ? ub - full : ub;
    sr   = s ? sa - sbv : sa + sbv;
    e.ovf  = (sr >= half) || (sr < -half);
    e.cout = s ? (ua >= ub) : ((ua + ub) >= full);
    raw    = (s ? ua - ub : ua + ub) & (full - 1);
    if (st && e.ovf) raw = (sa < 0) ? half : half - 1;
    e.result = raw[31:0];
    e.zero   = (raw == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic st, input bit glitch, output logic [31:0] r);
    exp_t e;
    int   edges, nbusy, extra, nd;
    nd = ndig_of(sel);
    @(negedge clk);
    drv_a = a; drv_b = b; drv_sub = s; drv_sat = st; drv_start = 1'b1;
    sb.push_back(model(width_of(sel), a, b, s, st));
    @(posedge clk);
    edges = 0;
    nbusy = 0;
    @(negedge clk);
    drv_start = 1'b0;
    while (w_done !== 1'b1 && edges < 200) begin
      if (w_busy === 1'b1) nbusy++;
      if (glitch && edges == 1) begin
        drv_start = 1'b1; drv_a = ~a; drv_b = a ^ b; drv_sub = ~s;
      end else begin
        drv_start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    drv_start = 1'b0;
    chk("latency", edges, nd);
    chk("busy_cycles", nbusy, nd);
    chk("busy_at_done", w_busy, 1'b0);
    e = sb.pop_front();
    chk("result", w_result, e.result);
    chk("cout", w_cout, e.cout);
    chk("ovf", w_ovf, e.ovf);
    chk("zero", w_zero, e.zero);
    r = w_result;
    @(negedge clk);
    chk("done_pulse", w_done, 1'b0);
    chk("hold_result", w_result, e.result);
    if (glitch) begin
      extra = 0;
      repeat (nd + 3) begin
        @(negedge clk);
        if (w_done === 1'b1) extra++;
      end
      chk("extra_done", extra, 0);
    end
  endtask

  initial begin
    int ndone;
    tests = 0; fails = 0; sel = 0;
    drv_start = 1'b0; drv_sub = 1'b0; drv_sat = 1'b0; drv_a = '0; drv_b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", w_busy, 1'b0);
    chk("rst_done", w_done, 1'b0);
    chk("rst_result", w_result, 32'd0);
    chk("rst_flags", {w_cout, w_ovf, w_zero}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'h0001, 32'h0003, 1'b0, 1'b0, 1'b0, res);
    chk("plan_add", res, 32'h0004);
    run_op(32'h0005, 32'h000C, 1'b1, 1'b0, 1'b0, res);
    chk("plan_sub_neg", res, 32'hFFF9);
    run_op(32'h1234, 32'h1234, 1'b1, 1'b0, 1'b0, res);
    chk("plan_sub_zero", {res, w_zero, w_cout}, {32'h0000, 2'b11});
    run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, res);
    chk("plan_ovf_wrap", {res, w_ovf}, {32'h8000, 1'b1});
    run_op(32'h7FFF, 32'h0001, 1'b0, 1'b1, 1'b0, res);
    chk("plan_sat_max", {res, w_ovf}, {32'h7FFF, 1'b1});
    run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, res);
    chk("plan_carry_wrap", {res, w_cout, w_ovf, w_zero}, {32'h0000, 3'b101});
    run_op(32'h8000, 32'h0001, 1'b1, 1'b0, 1'b0, res);
    chk("plan_sub_ovf", {res, w_cout, w_ovf}, {32'h7FFF, 2'b11});
    run_op(32'h8000, 32'h0001, 1'b1, 1'b1, 1'b0, res);
    chk("plan_sat_min", {res, w_ovf}, {32'h8000, 1'b1});
    run_op(32'h0100, 32'h0023, 1'b0, 1'b1, 1'b0, res);
    chk("sat_no_ovf", res, 32'h0123);
    run_op(32'h0010, 32'h0020, 1'b0, 1'b0, 1'b1, res);
    chk("glitch_ignored", res, 32'h0030);

    // Leave a non-zero held result, then abort an operation with reset.
    run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, res);
    @(negedge clk);
    drv_a = 32'h0101; drv_b = 32'h0202; drv_sub = 1'b0; drv_sat = 1'b0; drv_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", w_busy, 1'b0);
    chk("abort_done", w_done, 1'b0);
    chk("abort_result", w_result, 32'd0);
    chk("abort_flags", {w_cout, w_ovf, w_zero}, 3'b000);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (w_done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (w_done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(32'h0101, 32'h0202, 1'b0, 1'b0, 1'b0, res);
    chk("after_abort", res, 32'h0303);

    for (int i = 0; i < 16; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, res);
    end

    sel = 1;
    run_op(32'h7F, 32'h01, 1'b0, 1'b1, 1'b0, res);
    chk("w8_sat", res, 32'h7F);
    for (int i = 0; i < 8; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, res);
    end

    sel = 2;
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, res);
    chk("w32_sat_min", res, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, res);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
